// File: rtl/fetch_queue_stage_if.sv
// fetch_queue_stage_if: bus bundle between the fetch stage and execute, instruction memory and decode
//   redirect, redirect_pc                          execute -> fetch branch/jump target
//   imem_req, imem_addr, imem_ack, imem_rdata      fetch <-> instruction memory
//   dec_valid, dec_ready, dec_instr, dec_pc, dec_pc_plus4   fetch -> decode queue head
//   fq_count                                       current queue occupancy
//   modport master: the fetch stage; modport slave: its environment
interface fetch_queue_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                   redirect;
    logic [XLEN-1:0]        redirect_pc;
    logic                   imem_req;
    logic [XLEN-1:0]        imem_addr;
    logic                   imem_ack;
    logic [XLEN-1:0]        imem_rdata;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [XLEN-1:0]        dec_instr;
    logic [XLEN-1:0]        dec_pc;
    logic [XLEN-1:0]        dec_pc_plus4;
    logic [$clog2(DEPTH):0] fq_count;
    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, fq_count
    );
    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, fq_count
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC owner and instruction fetcher feeding decode through a DEPTH-entry queue
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  fetch_queue_stage_if.master: redirect in, imem request/response, decode handshake, occupancy
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    fetch_queue_stage_if.master bus
);
    localparam int        AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   rd, wr;
    logic [AW:0]     count;
    logic            pop, push;
    // PC+4 is recomputed from the stored PC at the head rather than kept per entry.
    // imem_req is gated by rst so no request leaks out while reset is held.
    always_comb begin
        bus.dec_valid    = count != '0;
        pop              = bus.dec_valid & bus.dec_ready;
        bus.imem_req     = rst & ~bus.redirect & ((count != FULL) | pop);
        push             = bus.imem_req & bus.imem_ack;
        bus.imem_addr    = pc;
        bus.dec_instr    = bus.dec_valid ? q_instr[rd] : '0;
        bus.dec_pc       = bus.dec_valid ? q_pc[rd] : '0;
        bus.dec_pc_plus4 = bus.dec_valid ? q_pc[rd] + XLEN'(4) : '0;
        bus.fq_count     = count;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pc    <= RESET_PC;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (bus.redirect) begin
            pc    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_instr[wr] <= bus.imem_rdata;
                q_pc[wr]    <= pc;
                wr          <= wr + AW'(1);
                pc          <= pc + XLEN'(4);
            end
            if (pop)
                rd <= rd + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: random and directed stimulus checked against a queue-based fetch model
module tb_fetch_queue_stage;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t        mq[$];
    logic [31:0] mpc;
    always #5 clk = ~clk;
    fetch_queue_stage_if #(.XLEN(32), .DEPTH(DEPTH)) aif ();
    fetch_queue_stage_if #(.XLEN(32), .DEPTH(DEPTH)) bif ();
    fetch_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst), .bus(aif.master)
    );
    fetch_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst), .bus(bif.master)
    );
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // One cycle: drive inputs at the falling edge, compare against the model, then advance the model
    // to what the coming rising edge must produce.
    task automatic step(input logic r, input logic [31:0] rp, input logic a, input logic rdy);
        ent_t e;
        logic pop, req, vld;
        @(negedge clk);
        aif.redirect    = r;
        aif.redirect_pc = rp;
        aif.imem_ack    = a;
        aif.imem_rdata  = $urandom;
        aif.dec_ready   = rdy;
        #1;
        vld = mq.size() != 0;
        pop = vld && rdy;
        req = !r && (mq.size() < DEPTH || pop);
        e.instr = 32'h0;
        e.pc    = 32'h0;
        if (vld) e = mq[0];
        check("imem_req", aif.imem_req, req);
        check("imem_addr", aif.imem_addr, mpc);
        check("dec_valid", aif.dec_valid, vld);
        check("dec_instr", aif.dec_instr, e.instr);
        check("dec_pc", aif.dec_pc, e.pc);
        check("dec_pc_plus4", aif.dec_pc_plus4, vld ? e.pc + 32'd4 : 32'h0);
        check("fq_count", aif.fq_count, 32'(mq.size()));
        if (r) begin
            mq.delete();
            mpc = rp & ~32'd3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (req && a) begin
                e.instr = aif.imem_rdata;
                e.pc    = mpc;
                mq.push_back(e);
                mpc += 32'd4;
            end
        end
    endtask
    initial begin
        aif.redirect = 0; aif.redirect_pc = 0; aif.imem_ack = 1; aif.imem_rdata = 0; aif.dec_ready = 1;
        bif.redirect = 0; bif.redirect_pc = 0; bif.imem_ack = 1; bif.imem_rdata = 32'hB0B0_0000; bif.dec_ready = 1;
        #3;
        check("rst_req_a", aif.imem_req, 0);
        check("rst_valid_a", aif.dec_valid, 0);
        check("rst_count_a", aif.fq_count, 0);
        check("rst_req_b", bif.imem_req, 0);
        repeat (2) @(posedge clk);
        check("rst_addr_a", aif.imem_addr, 32'h0);
        check("rst_addr_b", bif.imem_addr, 32'hFFFF_FFF8);
        @(posedge clk);
        #1 rst = 1;
        mq.delete();
        mpc = 32'h0;
        step(0, 0, 1, 1);
        check("t1_addr0", aif.imem_addr, 32'h0);
        check("t6_valid_b", bif.dec_valid, 0);
        step(0, 0, 1, 1);
        check("t1_pc0", aif.dec_pc, 32'h0);
        check("t1_pc0_plus4", aif.dec_pc_plus4, 32'h4);
        check("t6_pc_b0", bif.dec_pc, 32'hFFFF_FFF8);
        check("t6_instr_b0", bif.dec_instr, 32'hB0B0_0000);
        step(0, 0, 1, 1);
        check("t1_pc4", aif.dec_pc, 32'h4);
        check("t6_pc_b1", bif.dec_pc, 32'hFFFF_FFFC);
        check("t6_plus4_b1", bif.dec_pc_plus4, 32'h0);
        step(0, 0, 1, 1);
        check("t6_pc_b2", bif.dec_pc, 32'h0);
        repeat (10) step(0, 0, 1, 0);
        check("t2_full", aif.fq_count, 4);
        check("t2_req_off", aif.imem_req, 0);
        repeat (4) step(0, 0, 1, 1);
        step(1, 32'h10, 1, 1);
        repeat (3) begin
            step(0, 0, 0, 1);
            check("t3_hold", aif.imem_addr, 32'h10);
        end
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check("t3_push", aif.dec_pc, 32'h10);
        step(1, 32'h40, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(1, 32'h203, 1, 0);
        check("t4_three", aif.fq_count, 3);
        step(0, 0, 0, 0);
        check("t4_flush", aif.fq_count, 0);
        check("t4_nvalid", aif.dec_valid, 0);
        check("t4_addr", aif.imem_addr, 32'h200);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check("t4_first", aif.dec_pc, 32'h200);
        repeat (5) step(0, 0, 1, 0);
        step(1, 32'h80, 1, 1);
        check("t5_full", aif.fq_count, 4);
        step(0, 0, 1, 1);
        check("t5_empty", aif.fq_count, 0);
        for (int ph = 0; ph < 4; ph++)
            repeat (700)
                step($urandom_range(15) == 0, $urandom, $urandom_range(3) != 0,
                     $urandom_range(3) < 32'(ph + 1) - ((ph == 3) ? 32'd1 : 32'd0));
        repeat (3) step(0, 0, 1, 1);
        @(posedge clk);
        #2 rst = 0;
        #1;
        check("mid_req_a", aif.imem_req, 0);
        check("mid_valid_a", aif.dec_valid, 0);
        check("mid_instr_a", aif.dec_instr, 0);
        check("mid_pc_a", aif.dec_pc, 0);
        check("mid_plus4_a", aif.dec_pc_plus4, 0);
        check("mid_count_a", aif.fq_count, 0);
        check("mid_addr_a", aif.imem_addr, 32'h0);
        check("mid_addr_b", bif.imem_addr, 32'hFFFF_FFF8);
        check("mid_valid_b", bif.dec_valid, 0);
        @(posedge clk);
        #1 rst = 1;
        mq.delete();
        mpc = 32'h0;
        repeat (20) step(0, 0, $urandom_range(1), $urandom_range(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
